bcd_convert_ctrl: RTL and testbench

BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

---
 rtl/bcd_convert_ctrl_if.sv | 22 ++
 rtl/bcd_convert_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_convert_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_ctrl_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
interface bcd_convert_ctrl_if #(
   parameter int unsigned BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic [15:0]      bcd;
   logic             ovf;
   logic [3:0]       blank;

   modport master (
      output start, bin,
      input  busy, done, bcd, ovf, blank
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, ovf, blank
   );
endinterface

// File: rtl/bcd_convert_ctrl.sv
// Sequential shift-add-3 binary to 4-digit BCD converter with overflow saturation.
// Optional leading-zero blank mask is built only when BCD_LZB_EN is defined.
module bcd_convert_ctrl #(
   parameter int unsigned BIN_W = 14
) (
   input logic               clk,
   input logic               rst_n,
   bcd_convert_ctrl_if.slave bus
);
   localparam int unsigned CntW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e           state_q, state_d;
   logic [BIN_W-1:0] sh_q, sh_d;
   logic [15:0]      acc_q, acc_d, acc_adj;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             ovf_cap_q, ovf_cap_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             load_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StConv;
         StConv:  if (cnt_q == CntW'(1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != StIdle);
      bus.done = (state_q == StDone);
   end

   // Result registers load only on the final shift, so partial sums never reach bcd.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 4; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      load_result = (state_q == StConv) && (cnt_q == CntW'(1));
      sh_d        = sh_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_cap_d   = ovf_cap_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      if ((state_q == StIdle) && bus.start) begin
         sh_d      = bus.bin;
         acc_d     = '0;
         cnt_d     = CntW'(BIN_W);
         ovf_cap_d = (32'(bus.bin) > 32'd9999);
      end else if (state_q == StConv) begin
         acc_d = {acc_adj[14:0], sh_q[BIN_W-1]};
         sh_d  = {sh_q[BIN_W-2:0], 1'b0};
         cnt_d = cnt_q - CntW'(1);
      end
      if (load_result) begin
         bcd_d = ovf_cap_q ? 16'h9999 : acc_d;
         ovf_d = ovf_cap_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_cap_q <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         sh_q      <= sh_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_cap_q <= ovf_cap_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.bcd = bcd_q;
   assign bus.ovf = ovf_q;

`ifdef BCD_LZB_EN
   logic [3:0] blank_q, blank_d;

   always_comb begin
      blank_d = blank_q;
      if (load_result) begin
         blank_d[3] = (bcd_d[15:12] == 4'd0);
         blank_d[2] = blank_d[3] && (bcd_d[11:8] == 4'd0);
         blank_d[1] = blank_d[2] && (bcd_d[7:4] == 4'd0);
         blank_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign bus.blank = blank_q;
`else
   assign bus.blank = 4'b0000;
`endif
endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl: scoreboard of expected results checked on each done pulse.
module tb_bcd_convert_ctrl;
   localparam int unsigned BIN_W = 14;

   typedef struct packed {
      logic [15:0] bcd;
      logic        ovf;
      logic [3:0]  blank;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   exp_t exp_q[$];

   bcd_convert_ctrl_if #(.BIN_W(BIN_W)) bus ();

   bcd_convert_ctrl #(.BIN_W(BIN_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int v);
      exp_t e;
      int   d3, d2, d1;
      e.ovf = (v > 9999);
      if (e.ovf) begin
         e.bcd = 16'h9999;
         d3 = 9; d2 = 9; d1 = 9;
      end else begin
         d3 = v / 1000;
         d2 = (v / 100) % 10;
         d1 = (v / 10) % 10;
         e.bcd = {4'(d3), 4'(d2), 4'(d1), 4'(v % 10)};
      end
`ifdef BCD_LZB_EN
      e.blank[3] = (d3 == 0);
      e.blank[2] = e.blank[3] && (d2 == 0);
      e.blank[1] = e.blank[2] && (d1 == 0);
      e.blank[0] = 1'b0;
`else
      e.blank = 4'b0000;
`endif
      return e;
   endfunction

   // Scoreboard consumer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_bcd", 32'(bus.bcd), 32'(e.bcd));
               check("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
               check("sb_blank", 32'(bus.blank), 32'(e.blank));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // Call at a negedge with DUT idle; returns at the negedge after the accepting edge.
   task automatic start_conv(input int v);
      bus.bin   = BIN_W'(v);
      bus.start = 1'b1;
      exp_q.push_back(model(v));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int n = 0;
      while ((bus.done !== 1'b1) && (n < max)) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus.done), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt, done_at, d0, t, last, cnt;
      bus.start = 1'b0;
      bus.bin   = '0;
      #2;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      check("rst_blank", 32'(bus.blank), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Latency and busy window; bin changes after acceptance must not matter.
      start_conv(1234);
      bus.bin  = BIN_W'(777);
      busy_cnt = 0;
      done_at  = 0;
      for (int k = 1; k <= 18; k++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if ((bus.done === 1'b1) && (done_at == 0)) done_at = k;
         @(negedge clk);
      end
      check("lat_busy_cycles", 32'(busy_cnt), 32'd15);
      check("lat_done_cycle", 32'(done_at), 32'd15);

      start_conv(0);
      wait_done("done_zero", 20);
      start_conv(9999);
      wait_done("done_9999", 20);
      start_conv(12000);
      wait_done("done_12000", 20);
      check("hold_ovf", 32'(bus.ovf), 32'd1);
      check("hold_bcd", 32'(bus.bcd), 32'h9999);

      // Starts during CONV and during DONE are dropped.
      d0 = done_cnt;
      start_conv(56);
      repeat (3) @(negedge clk);
      bus.bin   = BIN_W'(7);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      t = 0;
      while ((bus.done !== 1'b1) && (t < 30)) begin
         @(negedge clk);
         t++;
      end
      check("ign_done_seen", 32'(bus.done), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      check("ign_done_count", 32'(done_cnt - d0), 32'd1);
      check("ign_idle_busy", 32'(bus.busy), 32'd0);

      // Reset mid-conversion aborts; restart right after release.
      start_conv(4321);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_bcd", 32'(bus.bcd), 32'd0);
      check("abort_ovf", 32'(bus.ovf), 32'd0);
      check("abort_blank", 32'(bus.blank), 32'd0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_conv(4321);
      check("restart_busy", 32'(bus.busy), 32'd1);
      wait_done("done_restart", 20);
      check("restart_done_count", 32'(done_cnt - d0), 32'd1);

      // Back-to-back conversions with start held high.
      bus.bin   = BIN_W'(16383);
      bus.start = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(model(16383));
      t    = 0;
      last = 0;
      cnt  = 0;
      while ((cnt < 3) && (t < 100)) begin
         @(negedge clk);
         t++;
         if (bus.done === 1'b1) begin
            if (cnt > 0) check("b2b_interval", 32'(t - last), 32'd16);
            last = t;
            cnt++;
            if (cnt == 3) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("b2b_count", 32'(cnt), 32'd3);
      repeat (20) @(negedge clk);
      check("b2b_idle_busy", 32'(bus.busy), 32'd0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
